// File: rtl/datapath_arbiter_if.sv
// Controller/datapath signal bundle for datapath_arbiter; master = controllers + datapath side, slave = arbiter.
// Latency: none (wires only). Backpressure: req/gnt ownership handshake.
interface datapath_arbiter_if;
    logic       req0, req1;
    logic       lock0, lock1;
    logic [2:0] op0, op1;
    logic [3:0] src1_0, src2_0, dest0;
    logic [3:0] src1_1, src2_1, dest1;
    logic       overflow;
    logic       gnt0, gnt1;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;
    logic       ovf0, ovf1;
    logic       err;

    modport master (
        output req0, req1, lock0, lock1, op0, op1,
        output src1_0, src2_0, dest0, src1_1, src2_1, dest1, overflow,
        input  gnt0, gnt1, op, src1, src2, dest, ovf0, ovf1, err
    );

    modport slave (
        input  req0, req1, lock0, lock1, op0, op1,
        input  src1_0, src2_0, dest0, src1_1, src2_1, dest1, overflow,
        output gnt0, gnt1, op, src1, src2, dest, ovf0, ovf1, err
    );
endinterface

// File: rtl/datapath_arbiter.sv
// Round-robin owner arbiter muxing two controllers onto the FIR datapath, with lock for atomic sequences.
// Latency: grant one cycle after request seen in IDLE; command/overflow muxing combinational.
// Backpressure: non-owner waits on gnt; ARB_TIMEOUT_EN adds forced lock release with err pulse.
module datapath_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          n_reset,
    datapath_arbiter_if.slave dp
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("datapath_arbiter: TIMEOUT must be at least 1");
    end

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   owned, own_req, own_lock, to_hit, hold;

    assign owned    = (state_q == OWN0) || (state_q == OWN1);
    assign own_req  = (state_q == OWN1) ? dp.req1  : dp.req0;
    assign own_lock = (state_q == OWN1) ? dp.lock1 : dp.lock0;
    assign hold     = owned && own_req && own_lock && !to_hit;

`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts owned cycles already completed, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign to_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign cnt_d  = hold ? cnt_q + CW'(1) : '0;
    assign dp.err = owned && own_req && own_lock && to_hit;
`else
    assign to_hit = 1'b0;
    assign dp.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (dp.req0 && dp.req1) state_d = ptr_q ? OWN1 : OWN0;
                else if (dp.req0)       state_d = OWN0;
                else if (dp.req1)       state_d = OWN1;
            end
            OWN0: begin
                if (!hold) begin
                    ptr_d = 1'b1;
                    if (dp.req1)      state_d = OWN1;
                    else if (dp.req0) state_d = OWN0;
                    else              state_d = IDLE;
                end
            end
            OWN1: begin
                if (!hold) begin
                    ptr_d = 1'b0;
                    if (dp.req0)      state_d = OWN0;
                    else if (dp.req1) state_d = OWN1;
                    else              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The owner's fields pass through only while it actually presents an op.
    always_comb begin
        dp.op   = 3'd0;
        dp.src1 = 4'd0;
        dp.src2 = 4'd0;
        dp.dest = 4'd0;
        if (state_q == OWN0 && dp.req0) begin
            dp.op   = dp.op0;
            dp.src1 = dp.src1_0;
            dp.src2 = dp.src2_0;
            dp.dest = dp.dest0;
        end else if (state_q == OWN1 && dp.req1) begin
            dp.op   = dp.op1;
            dp.src1 = dp.src1_1;
            dp.src2 = dp.src2_1;
            dp.dest = dp.dest1;
        end
    end

    assign dp.gnt0 = (state_q == OWN0);
    assign dp.gnt1 = (state_q == OWN1);
    assign dp.ovf0 = dp.overflow && dp.gnt0 && dp.req0;
    assign dp.ovf1 = dp.overflow && dp.gnt1 && dp.req1;
endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: reset, single op, fairness, atomic burst, overflow routing, lock/timeout.
// Built with or without ARB_TIMEOUT_EN; TIMEOUT is set to 4.
module tb_datapath_arbiter;
    logic clk;
    logic n_reset;
    int   n_checks;
    int   n_errors;

    datapath_arbiter_if dp_if();

    datapath_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .dp      (dp_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_reset  = 1'b0;
        dp_if.req0 = 0; dp_if.req1 = 0; dp_if.lock0 = 0; dp_if.lock1 = 0;
        dp_if.op0 = 0; dp_if.op1 = 0;
        dp_if.src1_0 = 0; dp_if.src2_0 = 0; dp_if.dest0 = 0;
        dp_if.src1_1 = 0; dp_if.src2_1 = 0; dp_if.dest1 = 0;
        dp_if.overflow = 0;

        #12;
        check("rst_gnt0", dp_if.gnt0, 0);
        check("rst_gnt1", dp_if.gnt1, 0);
        check("rst_op",   dp_if.op,   0);
        check("rst_err",  dp_if.err,  0);

        // single unlocked op from channel 0
        next_cycle();
        n_reset = 1'b1;
        dp_if.req0 = 1; dp_if.op0 = 3'd4; dp_if.src1_0 = 0; dp_if.src2_0 = 4'd10; dp_if.dest0 = 0;
        @(negedge clk);
        check("idle_gnt0", dp_if.gnt0, 0);
        check("idle_op",   dp_if.op,   0);
        next_cycle();
        @(negedge clk);
        check("single_gnt0", dp_if.gnt0, 1);
        check("single_gnt1", dp_if.gnt1, 0);
        check("single_op",   dp_if.op,   4);
        check("single_src2", dp_if.src2, 10);
        check("single_dest", dp_if.dest, 0);
        next_cycle();
        dp_if.req0 = 0;
        @(negedge clk);
        check("drop_gnt0", dp_if.gnt0, 1);
        check("drop_op",   dp_if.op,   0);
        next_cycle();

        // fairness: ptr now points at channel 1
        dp_if.req0 = 1; dp_if.req1 = 1; dp_if.op0 = 3'd1; dp_if.op1 = 3'd5;
        @(negedge clk);
        check("after_gnt0", dp_if.gnt0, 0);
        check("after_gnt1", dp_if.gnt1, 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check("rr_gnt1", dp_if.gnt1, (i % 2 == 0) ? 1 : 0);
            check("rr_gnt0", dp_if.gnt0, (i % 2 == 0) ? 0 : 1);
            check("rr_op",   dp_if.op,   (i % 2 == 0) ? 5 : 1);
        end
        next_cycle();
        dp_if.req0 = 0; dp_if.req1 = 0;
        @(negedge clk);
        check("rr_tail_gnt1", dp_if.gnt1, 1);
        check("rr_tail_op",   dp_if.op,   0);
        next_cycle();

        // atomic MUL-then-ADD with channel 1 pending, ptr back at 0
        dp_if.req0 = 1; dp_if.lock0 = 1; dp_if.op0 = 3'd6;
        dp_if.src1_0 = 4'd4; dp_if.src2_0 = 4'd9; dp_if.dest0 = 4'd10;
        dp_if.req1 = 1; dp_if.lock1 = 0; dp_if.op1 = 3'd5;
        @(negedge clk);
        check("burst_idle_gnt0", dp_if.gnt0, 0);
        next_cycle();
        @(negedge clk);
        check("mul_gnt0", dp_if.gnt0, 1);
        check("mul_op",   dp_if.op,   6);
        check("mul_src1", dp_if.src1, 4);
        check("mul_src2", dp_if.src2, 9);
        check("mul_dest", dp_if.dest, 10);
        next_cycle();
        dp_if.op0 = 3'd4; dp_if.src1_0 = 0; dp_if.src2_0 = 4'd10; dp_if.dest0 = 4'd10; dp_if.lock0 = 0;
        @(negedge clk);
        check("add_gnt0", dp_if.gnt0, 1);
        check("add_op",   dp_if.op,   4);
        check("add_src2", dp_if.src2, 10);
        next_cycle();
        dp_if.req0 = 0; dp_if.overflow = 1;
        @(negedge clk);
        check("handover_gnt1", dp_if.gnt1, 1);
        check("handover_gnt0", dp_if.gnt0, 0);
        check("handover_op",   dp_if.op,   5);
        check("ovf_owner",     dp_if.ovf1, 1);
        check("ovf_other",     dp_if.ovf0, 0);
        next_cycle();
        dp_if.req1 = 0;
        @(negedge clk);
        check("ovf_noreq",  dp_if.ovf1, 0);
        check("noreq_op",   dp_if.op,   0);
        next_cycle();
        @(negedge clk);
        check("ovf_idle0", dp_if.ovf0, 0);
        check("ovf_idle1", dp_if.ovf1, 0);
        check("idle2_gnt1", dp_if.gnt1, 0);
        dp_if.overflow = 0;

        // long lock on channel 0 with channel 1 pending
        dp_if.req0 = 1; dp_if.lock0 = 1; dp_if.op0 = 3'd2; dp_if.dest0 = 4'd3;
        dp_if.req1 = 1; dp_if.lock1 = 0; dp_if.op1 = 3'd1;
        next_cycle();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_gnt0", dp_if.gnt0, 1);
            check("to_err",  dp_if.err,  (i == 3) ? 1 : 0);
            next_cycle();
        end
`else
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lock_gnt0", dp_if.gnt0, 1);
            check("lock_err",  dp_if.err,  0);
            if (i == 5) dp_if.lock0 = 0;
            next_cycle();
        end
`endif
        @(negedge clk);
        check("lock_rel_gnt1", dp_if.gnt1, 1);
        check("lock_rel_err",  dp_if.err,  0);
        dp_if.req0 = 0; dp_if.lock1 = 1; dp_if.op1 = 3'd3; dp_if.dest1 = 4'd7; dp_if.src1_1 = 4'd2;

        // asynchronous reset in the middle of a channel 1 burst
        next_cycle();
        @(negedge clk);
        check("burst1_gnt1", dp_if.gnt1, 1);
        check("burst1_dest", dp_if.dest, 7);
        #1;
        n_reset = 1'b0;
        #1;
        check("arst_gnt1", dp_if.gnt1, 0);
        check("arst_op",   dp_if.op,   0);
        check("arst_dest", dp_if.dest, 0);
        check("arst_src1", dp_if.src1, 0);
        check("arst_err",  dp_if.err,  0);
        next_cycle();
        n_reset = 1'b1;
        dp_if.req0 = 1; dp_if.req1 = 1; dp_if.lock0 = 0; dp_if.lock1 = 0;
        next_cycle();
        @(negedge clk);
        check("post_rst_gnt0", dp_if.gnt0, 1);
        check("post_rst_gnt1", dp_if.gnt1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/datapath_arbiter.md
# datapath_arbiter

Shares the single FIR arithmetic datapath (register file + ALU driven by `op`/`src1`/`src2`/`dest`) between two sequencing controllers. Each controller requests ownership; the arbiter grants one at a time, round-robin, with an optional lock for atomic multi-op sequences such as MUL-then-ADD through scratch register 10. The arbiter sits between the controllers and the datapath. It muxes the owner's command onto the datapath and routes `overflow` back to the owner only.

## Interface
- `TIMEOUT`, default 16: maximum consecutive owned cycles with lock held before a forced release (used only under `ARB_TIMEOUT_EN`).

- `clk` in 1: system clock, rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: ownership request / op-valid from controller 0 / 1.
- `lock0`, `lock1` in 1: keep ownership after the current cycle.
- `op0`, `op1` in 3: command op. Encoding: NOP=0, COPY=1, LOADONE=2, LOADTWO=3, ADD=4, SUB=5, MUL=6.
- `src1_0`, `src2_0`, `dest0`, `src1_1`, `src2_1`, `dest1` in 4 each: register indices.
- `overflow` in 1: datapath overflow for the op presented this cycle.
- `gnt0`, `gnt1` out 1: ownership indication, registered and one-hot-or-zero.
- `op` out 3: command driven to the datapath.
- `src1`, `src2`, `dest` out 4 each: indices driven to the datapath.
- `ovf0`, `ovf1` out 1: overflow routed to the owner.
- `err` out 1: forced-release pulse. Tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- States: IDLE, OWN0, OWN1. Round-robin pointer `ptr` (1 bit) names the preferred channel.
- `gnt0` = (state==OWN0) and `gnt1` = (state==OWN1). Both are registered, so they change only on a clock edge or on reset.
- Datapath command:
  - In OWNx with `reqx`=1: outputs = channel x fields, combinational pass-through.
  - Otherwise: `op`=NOP, `src1`=`src2`=`dest`=0.
- `ovfx` = `overflow` & `gntx` & `reqx`. The non-owner always sees 0.
- IDLE transitions:
  - Both requests high → OWN[`ptr`].
  - One request high → that OWN.
  - Neither high → stay in IDLE.
- OWNx transitions:
  - `reqx`=1 & `lockx`=1 & no timeout → stay.
  - Otherwise release and set `ptr` = other channel. Next state: OWN[other] if the other request is high, else OWNx if `reqx`=1, else IDLE.
- Back-to-back handover has no NOP bubble.
- A request asserted in the same cycle as a release is honoured by the rule above.
- Dropping `reqx` while still owning outputs NOP that cycle, then releases.
- Reset, including mid-burst, forces immediately and asynchronously: state=IDLE, `ptr`=0, `gnt0`=`gnt1`=0, `op`=0, `src1`=`src2`=`dest`=0, `ovf0`=`ovf1`=0, `err`=0, timeout counter=0.

## Timing
- Grant latency: a request first seen in IDLE at edge N gets its grant after edge N, so `gnt` is high in cycle N+1. The op issues in that cycle.
- Single unlocked op: exactly one owned cycle.
- Locked burst of k ops: k consecutive owned cycles. The release is decided in the cycle where `lock` is low, so hold `lock`=1 on all ops except the last.
- `overflow` is sampled in the same cycle as the op. `ovfx` is combinational and valid in that same cycle.
- Throughput: one datapath op per cycle when any request is pending.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - Counter width = $clog2(TIMEOUT+1). It clears on entry to OWNx and increments each owned cycle.
  - When the count reaches `TIMEOUT` with `lockx`=1, the arbiter releases as if `lockx`=0 and pulses `err` high for exactly that cycle.
  - If the other channel is not requesting, the same owner is re-granted with a fresh count.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; `lock` is honoured indefinitely; `err` is constant 0.

## Test plan
- Reset: pull `n_reset` low during an OWN1 burst → `gnt1`, `op`, `dest` go to 0 before the next edge; after release, `req0`=`req1`=1 grants `gnt0` first.
- Single op: `req0`=1, `lock0`=0, `op0`=4, `src1_0`=0, `src2_0`=10, `dest0`=0 → `gnt0`=1 one cycle later with `op`=4, `src2`=10; then IDLE, `op`=0.
- Fairness: both requesting continuously, `lock`=0 → grants alternate 0,1,0,1 with no idle cycle.
- Atomic burst: `req0` with MUL (6, src1=4, src2=9, dest=10, `lock0`=1) then ADD (4, src2=10, `lock0`=0), while `req1` is pending → `gnt0` for 2 cycles, `gnt1` on the 3rd cycle.
- Overflow routing: `overflow`=1 while `gnt1` and `req1` are high → `ovf1`=1, `ovf0`=0. `overflow`=1 in IDLE → both 0.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT`=4): `lock0` held high with `req1` pending → `gnt0` for 4 cycles, `err`=1 on the 4th, `gnt1` on the 5th.
